// File: rtl/bus_arbiter.sv
// Round-robin data-bus arbiter with bounded hold time and a one-cycle dead gap between grants.
// Requester 0 is the CPU control unit; any other holder halts the CPU.
module bus_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         done,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    bus_busy,
   output logic                    halt_cpu,
   output logic                    timeout
);

   localparam int unsigned IdW  = $clog2(NREQ);
   localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   state_e           state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [IdW-1:0]   id_q, id_d;
   logic [IdW-1:0]   last_id_q, last_id_d;
   logic [CntW-1:0]  hold_q, hold_d;
   logic             timeout_q, timeout_d;

   logic [IdW-1:0]   cand;
   logic [IdW-1:0]   winner;
   logic             release_now;
   logic             others_waiting;
   logic             expire_now;

   // Walk downward over offsets so the smallest offset from last_id+1 is the last one written.
   always_comb begin
      cand   = '0;
      winner = '0;
      for (int off = int'(NREQ); off > 0; off--) begin
         cand = IdW'((int'(last_id_q) + off) % int'(NREQ));
         if (req[cand]) winner = cand;
      end
   end

   assign release_now    = ((done & grant_q) != '0) || ((req & grant_q) == '0);
   assign others_waiting = (req & ~grant_q) != '0;
   // Covers both the exact expiry cycle and a saturated holder that later sees contention.
   assign expire_now     = others_waiting && (hold_q >= CntW'(MAX_HOLD - 1));

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      id_d      = id_q;
      last_id_d = last_id_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req != '0) begin
               state_d   = StGrant;
               grant_d   = NREQ'(1) << winner;
               id_d      = winner;
               last_id_d = winner;
               hold_d    = '0;
            end
         end
         StGrant: begin
            if (hold_q != CntW'(MAX_HOLD)) hold_d = hold_q + CntW'(1);
            if (release_now || expire_now) begin
               state_d   = StGap;
               grant_d   = '0;
               id_d      = '0;
               timeout_d = !release_now;
            end
         end
         StGap: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         id_q      <= '0;
         last_id_q <= IdW'(NREQ - 1);
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         id_q      <= id_d;
         last_id_q <= last_id_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = id_q;
   assign bus_busy = state_q != StIdle;
   assign halt_cpu = (state_q == StGrant) && (id_q != '0);
   assign timeout  = timeout_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of data-bus requesters; requester 0 is the CPU control unit. Legal range 2..8.
REQ-002 Parameter MAX_HOLD, default 16: cycles a grant may be held while another requester waits. Legal range 2..255.
REQ-003 clk  input  1  system clock (prescaled CPU clock); all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester level request; bit i belongs to requester i.
REQ-006 done  input  NREQ  per-requester single-cycle release strobe.
REQ-007 grant  output  NREQ  one-hot or all-zero bus grant, registered.
REQ-008 grant_id  output  clog2(NREQ)  index of the current holder; 0 when idle.
REQ-009 bus_busy  output  1  high whenever the state is not IDLE.
REQ-010 halt_cpu  output  1  high while a requester other than 0 holds grant; feeds the CPU halt OR-term.
REQ-011 timeout  output  1  single-cycle pulse when a grant is revoked by hold expiry.

Function
REQ-012 The state machine SHALL have three states: IDLE, GRANT and GAP.
REQ-013 IDLE with any req bit set: the arbiter SHALL choose the first set bit searching upward from (last_id+1) mod NREQ, wrapping.
  - The chosen grant bit SHALL assert on the next edge, giving one cycle of request-to-grant latency.
  - The state SHALL move to GRANT.
  - last_id SHALL be loaded with the winner.
REQ-014 IDLE with req all zero: the arbiter SHALL stay in IDLE with grant = 0.
REQ-015 GRANT: hold_cnt SHALL start at 0 on grant and increment each cycle, saturating at MAX_HOLD.
REQ-016 GRANT: the grant SHALL be released (move to GAP) when either of these holds:
  - done[grant_id] = 1, or
  - req[grant_id] = 0.
REQ-017 GRANT: when hold_cnt = MAX_HOLD-1 and any other req bit is set, the arbiter SHALL revoke the grant.
  - The state SHALL move to GAP.
  - timeout SHALL pulse for exactly that cycle.
REQ-018 GRANT: when hold_cnt reaches MAX_HOLD with no other request pending, the holder SHALL keep the grant indefinitely.
  - If another request appears later, revocation SHALL occur on the first cycle it is seen, with a timeout pulse.
REQ-019 If release (REQ-016) and expiry (REQ-017) occur in the same cycle, the event SHALL be treated as a release, with no timeout pulse.
REQ-020 GAP: grant SHALL be all zero for exactly one cycle, giving a dead cycle on the wired-OR bus, then the state SHALL return to IDLE.
  - Back-to-back grants are therefore separated by 2 cycles: GAP followed by the IDLE decision.
REQ-021 done bits of non-holders SHALL be ignored in all states, as SHALL done bits in IDLE and GAP.
REQ-022 grant SHALL never have more than one bit set, and SHALL never change except through IDLE->GRANT or GRANT->GAP.
REQ-023 grant_id SHALL equal the index of the set grant bit, and SHALL be 0 when grant = 0.
REQ-024 halt_cpu SHALL be combinationally equal to (state == GRANT && grant_id != 0).
REQ-025 A requester that drops and re-raises req while in GAP SHALL be re-arbitrated normally.
  - Round-robin order SHALL ensure no requester waits more than NREQ-1 grants.

Reset
REQ-026 On reset the outputs SHALL take these values:
  - state = IDLE
  - grant = 0
  - grant_id = 0
  - bus_busy = 0
  - halt_cpu = 0
  - timeout = 0
  - hold_cnt = 0
  - last_id = NREQ-1, so requester 0 wins the first contended arbitration.
REQ-027 Reset asserted mid-GRANT SHALL drop grant immediately (asynchronously), with no timeout pulse.
  - After reset deasserts, arbitration SHALL resume from the REQ-026 values.

Verification
REQ-028 The bench SHALL cover these directed scenarios (NREQ=4, MAX_HOLD=16):
  - Reset release, req=4'b1111 on cycle 0:
    - grant=0001 on cycle 1.
    - done[0] on cycle 3 -> GAP on cycle 4.
    - grant=0010 on cycle 6.
    - Order continues 0100 -> 1000 -> 0001.
  - Single requester 2, req held, no done, others idle -> grant stays 0100 for 100 cycles with no timeout.
    - Then req[1] rises -> the next cycle shows grant=0, timeout=1.
    - grant=0010 follows two cycles later.
  - Requester 1 granted, req[3] pending, no done:
    - timeout pulses on the 16th grant cycle.
    - halt_cpu is 1 throughout the grant and 0 in GAP.
  - done[2] while requester 1 holds -> no effect.
    - Requester 1 drops req without done -> GAP, then IDLE.
  - Release and expiry in the same cycle -> GAP entered, timeout stays 0.
  - Reset pulse while grant=1000 -> grant=0 immediately.
    - After release, req=1010 -> grant=0010 first.
REQ-029 Assertions SHALL hold on every cycle:
  - grant is one-hot or zero.
  - grant is zero on the cycle after any grant drop.
  - grant_id is consistent with grant.
  - timeout is never asserted for two consecutive cycles.
